// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared serial link framing constants, frame length and FSM states
//
// Purpose: definitions common to the serializer and deserializer stages.
//   START_BIT  : line level of the start bit
//   STOP_BIT   : line level of a valid stop bit (also the idle level)
//   frame_len  : total frame length in bits for a given word width
//   link_state_t : receive/transmit FSM states

package serial_link_pkg;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } link_state_t;

  // start + data bits + parity + stop
  function automatic int frame_len(input int txn_sz);
    return txn_sz + 3;
  endfunction

endpackage

// File: rtl/deserializer.sv
// rtl/deserializer.sv - serial frame receiver with one-word output register
//
// Purpose: receives frames of start '1', TXN_SZ data bits MSB first, even
// parity bit (XOR of data), stop '0', and presents good words on a
// valid/ready output register.
//
// Optional feature: define DESERIALIZER_PARITY_CHECK_EN to check the parity
// bit; otherwise the parity cycle is consumed but ignored and parity_err is 0.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   sin        in   serial line, one bit per clock
//   data       out  received word, valid while out_valid=1
//   out_valid  out  output register holds a word
//   out_ready  in   consumer accepts the word when out_valid=1
//   busy       out  a frame is in progress
//   parity_err out  one-cycle pulse on parity mismatch
//   frame_err  out  one-cycle pulse on bad stop bit
//   overrun    out  one-cycle pulse when a good word is dropped

module deserializer
  import serial_link_pkg::*;
#(
  parameter int TXN_SZ = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sin,
  output logic [TXN_SZ-1:0] data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = (TXN_SZ > 1) ? $clog2(TXN_SZ) : 1;

  link_state_t       state;
  link_state_t       next_state;
  logic [CW-1:0]     cnt;
  logic [TXN_SZ-1:0] shreg;
  logic              par_ok;

  logic start_det;
  logic shift_en;
  logic stop_cycle;
  logic stop_ok;
  logic good;
  logic handshake;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sin == START_BIT) next_state = DATA;
      DATA:    if (cnt == '0) next_state = PARITY;
      PARITY:  next_state = STOP;
      STOP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs and per-cycle strobes
  always_comb begin
    busy       = 1'b0;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    stop_cycle = 1'b0;
    case (state)
      IDLE:    start_det  = (sin == START_BIT);
      DATA:    begin busy = 1'b1; shift_en = 1'b1; end
      PARITY:  busy = 1'b1;
      STOP:    begin busy = 1'b1; stop_cycle = 1'b1; end
      default: busy = 1'b0;
    endcase
  end

`ifdef DESERIALIZER_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY) par_bit <= sin;
      // a bad stop bit masks the parity result for that frame
      parity_err <= stop_cycle && stop_ok && !par_ok;
    end
  end

  assign par_ok = ((^shreg) == par_bit);
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign stop_ok   = (sin == STOP_BIT);
  assign good      = stop_cycle && stop_ok && par_ok;
  assign handshake = out_valid && out_ready;

  // Bit counter and shift register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt   <= '0;
      shreg <= '0;
    end else begin
      if (start_det) begin
        cnt <= CW'(TXN_SZ - 1);
      end else if (shift_en && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (shift_en) begin
        shreg <= {shreg[TXN_SZ-2:0], sin};
      end
    end
  end

  // Output register and status pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data      <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_cycle && !stop_ok;
      overrun   <= good && out_valid && !out_ready;
      // a word arriving on the handshake edge replaces the consumed one
      if (good && (!out_valid || out_ready)) begin
        data      <= shreg;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed self-checking bench for deserializer

module tb_deserializer;
  import serial_link_pkg::*;

  localparam int W = 8;

  logic         clock;
  logic         reset_n;
  logic         sin;
  logic [W-1:0] data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         parity_err;
  logic         frame_err;
  logic         overrun;

  int checks;
  int errors;

  int n_perr;
  int n_ferr;
  int n_ovr;
  logic [W-1:0] acc_q[$];

  deserializer #(.TXN_SZ(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sin       (sin),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters and accepted-word log, sampled mid-cycle
  always @(negedge clock) begin
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (overrun)    n_ovr  <= n_ovr + 1;
    if (reset_n && out_valid && out_ready) acc_q.push_back(data);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    sin = b;
    tick();
  endtask

  task automatic drive_frame(input logic [W-1:0] w, input logic p, input logic s);
    drive_bit(START_BIT);
    for (int i = W - 1; i >= 0; i--) drive_bit(w[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    sin       = 1'b0;
    out_ready = 1'b0;
    tick(); tick(); tick();
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b exp 000", {parity_err, frame_err, overrun});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int q0;
    q0 = acc_q.size();
    out_ready = 1'b1;
    // start + data + parity: 9 edges after start, stop not yet sampled
    drive_bit(START_BIT);
    for (int i = W - 1; i >= 0; i--) drive_bit(logic'(8'hA5 >> i));
    drive_bit(1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
    drive_bit(STOP_BIT);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", data); end
    drive_bit(1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_width got %b exp 0", out_valid); end
    checks++; if (acc_q.size() !== q0 + 1 || acc_q[acc_q.size()-1] !== 8'hA5) begin
      errors++; $display("FAIL single_accept got n=%0d exp n=%0d word a5", acc_q.size() - q0, 1);
    end
  endtask

  task automatic test_back_to_back();
    int o0, p0, f0, q0;
    o0 = n_ovr; p0 = n_perr; f0 = n_ferr; q0 = acc_q.size();
    out_ready = 1'b0;
    drive_frame(8'hA5, 1'b0, STOP_BIT);
    drive_frame(8'h01, 1'b1, STOP_BIT);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_pulse got %b exp 1", overrun); end
    checks++; if (out_valid !== 1'b1 || data !== 8'hA5) begin
      errors++; $display("FAIL b2b_held got valid=%b data=%h exp valid=1 data=a5", out_valid, data);
    end
    sin = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun_width got %b exp 0", overrun); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_clear got %b exp 0", out_valid); end
    tick();
    checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL b2b_overrun_count got %0d exp 1", n_ovr - o0); end
    checks++; if (n_perr - p0 !== 0 || n_ferr - f0 !== 0) begin
      errors++; $display("FAIL b2b_errors got perr=%0d ferr=%0d exp 0 0", n_perr - p0, n_ferr - f0);
    end
    checks++; if (acc_q.size() !== q0 + 1 || acc_q[acc_q.size()-1] !== 8'hA5) begin
      errors++; $display("FAIL b2b_read got n=%0d exp 1 word a5", acc_q.size() - q0);
    end
  endtask

  task automatic test_parity();
    int p0;
    p0 = n_perr;
    out_ready = 1'b0;
    drive_frame(8'h3C, 1'b1, STOP_BIT);
`ifdef DESERIALIZER_PARITY_CHECK_EN
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_pulse got %b exp 1", parity_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL parity_valid got %b exp 0", out_valid); end
    drive_bit(1'b0);
    checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL parity_count got %0d exp 1", n_perr - p0); end
`else
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_off_pulse got %b exp 0", parity_err); end
    checks++; if (out_valid !== 1'b1 || data !== 8'h3C) begin
      errors++; $display("FAIL parity_off_data got valid=%b data=%h exp valid=1 data=3c", out_valid, data);
    end
    drive_bit(1'b0);
    checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL parity_off_count got %0d exp 0", n_perr - p0); end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL parity_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_frame_err();
    out_ready = 1'b1;
    drive_frame(8'hFF, 1'b0, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got %b exp 1", frame_err); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ferr_no_perr got %b exp 0", parity_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy got %b exp 0", busy); end
    drive_bit(1'b0);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_width got %b exp 0", frame_err); end
  endtask

  task automatic test_reset_mid();
    int p0, f0, o0;
    p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    out_ready = 1'b1;
    drive_bit(START_BIT);
    for (int i = W - 1; i >= 4; i--) drive_bit(logic'(8'h5A >> i));
    reset_n = 1'b0;
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    reset_n = 1'b1;
    drive_frame(8'h5A, 1'b0, STOP_BIT);
    checks++; if (out_valid !== 1'b1 || data !== 8'h5A) begin
      errors++; $display("FAIL rst_mid_data got valid=%b data=%h exp valid=1 data=5a", out_valid, data);
    end
    drive_bit(1'b0);
    checks++; if (n_perr != p0 || n_ferr != f0 || n_ovr != o0) begin
      errors++; $display("FAIL rst_mid_pulses got perr=%0d ferr=%0d ovr=%0d exp 0 0 0", n_perr - p0, n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] w;
    int q0, p0, f0, o0, n_bad;
    q0 = acc_q.size(); p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
    n_bad = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      w = W'($urandom);
      exp_q.push_back(w);
      drive_frame(w, ^w, STOP_BIT);
    end
    drive_bit(1'b0);
    drive_bit(1'b0);
    checks++; if (acc_q.size() - q0 !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", acc_q.size() - q0, exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && q0 + k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[q0 + k] !== exp_q[k]) begin
        errors++; n_bad++;
        if (n_bad < 5) $display("FAIL rand_word[%0d] got %h exp %h", k, acc_q[q0 + k], exp_q[k]);
      end
    end
    checks++; if (n_perr != p0 || n_ferr != f0 || n_ovr != o0) begin
      errors++; $display("FAIL rand_pulses got perr=%0d ferr=%0d ovr=%0d exp 0 0 0", n_perr - p0, n_ferr - f0, n_ovr - o0);
    end
    checks++; if (frame_len(W) !== 11) begin
      errors++; $display("FAIL frame_len got %0d exp 11", frame_len(W));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    n_perr = 0;
    n_ferr = 0;
    n_ovr  = 0;
    reset_n   = 1'b0;
    sin       = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
